// File: rtl/dram_axi_port.sv
// dram_axi_port: single-beat AXI4 master bridging the core DRAM port to MIG, with a posted-write queue.
// Defining DRAM_LINEBUF_EN adds a one-line read buffer with write-through merge.
module dram_axi_port #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_DATA_W = 128,
  parameter int WQ_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dram_oe,
  input  logic [ADDR_W-1:0]       dram_addr,
  input  logic [DATA_W-1:0]       dram_wdata,
  input  logic [DATA_W/8-1:0]     dram_we,
  output logic [DATA_W-1:0]       dram_rdata,
  output logic                    dram_valid,
  output logic                    dram_busy,
  output logic                    axi_err,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_wready,
  input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);
  localparam int AB  = AXI_DATA_W / 8;
  localparam int DB  = DATA_W / 8;
  localparam int LAB = $clog2(AB);
  localparam int LDB = $clog2(DB);
  localparam int QW  = $clog2(WQ_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_AR, R_R} rstate_t;

  function automatic logic [DATA_W-1:0] pick(input logic [AXI_DATA_W-1:0] d,
                                             input logic [LAB-1:0] ln, input logic [LDB-1:0] of);
    logic [DATA_W-1:0] w;
    w = DATA_W'(d >> (DATA_W * ln));
    return w >> (8 * of);
  endfunction

  logic [LAB-1:0]        lo, lane;
  logic [LDB-1:0]        off;
  logic [ADDR_W-1:0]     base;
  logic [DATA_W-1:0]     wd_sh;
  logic [DB-1:0]         we_sh;
  logic [AXI_DATA_W-1:0] wdata_e;
  logic [AB-1:0]         wstrb_e;
  logic                  accept, push, pop, rd_acc, full, empty, lb_hit;
  logic [AXI_DATA_W-1:0] lb_rd;

  assign lo      = dram_addr[LAB-1:0];
  assign off     = lo[LDB-1:0];
  assign lane    = lo >> LDB;
  assign base    = {dram_addr[ADDR_W-1:LAB], {LAB{1'b0}}};
  assign wd_sh   = dram_wdata << (8 * off);
  assign we_sh   = dram_we << off;
  assign wdata_e = AXI_DATA_W'(wd_sh) << (DATA_W * lane);
  assign wstrb_e = AB'(we_sh) << (DB * lane);

  logic [ADDR_W-1:0]     q_addr [WQ_DEPTH];
  logic [AXI_DATA_W-1:0] q_data [WQ_DEPTH];
  logic [AB-1:0]         q_strb [WQ_DEPTH];
  logic [QW-1:0]         wp_q, rp_q;
  logic [QW:0]           cnt_q;

  wstate_t wst_q, wst_d;
  rstate_t rs_q, rs_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d, dram_valid_q, dram_valid_d;
  logic [DATA_W-1:0] dram_rdata_q, dram_rdata_d;
  logic [ADDR_W-1:0] ra_q;
  logic [LAB-1:0]    rlane_q;
  logic [LDB-1:0]    roff_q;

  assign full      = cnt_q == (QW+1)'(WQ_DEPTH);
  assign empty     = cnt_q == '0;
  assign dram_busy = full | (rs_q != R_IDLE);
  assign accept    = dram_oe & ~dram_busy;
  assign push      = accept & (|dram_we);
  assign rd_acc    = accept & ~(|dram_we);
  assign pop       = (wst_q == W_RESP) & m_axi_bvalid;
  assign err_d     = err_q | (m_axi_rvalid & (|m_axi_rresp)) | (m_axi_bvalid & (|m_axi_bresp));

  always_comb begin
    wst_d     = wst_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wst_q)
      W_IDLE: if (!empty) begin
        wst_d     = W_SEND;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      W_SEND: begin
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready);
        wst_d     = (aw_done_d & w_done_d) ? W_RESP : W_SEND;
      end
      W_RESP: wst_d = m_axi_bvalid ? W_IDLE : W_RESP;
      default: wst_d = W_IDLE;
    endcase
  end

  // Reads wait in R_DRAIN until every posted write has its response, keeping RAW order.
  always_comb begin
    rs_d         = rs_q;
    dram_rdata_d = dram_rdata_q;
    dram_valid_d = 1'b0;
    case (rs_q)
      R_IDLE:  rs_d = (rd_acc & ~lb_hit) ? R_DRAIN : R_IDLE;
      R_DRAIN: rs_d = (empty & (wst_q == W_IDLE)) ? R_AR : R_DRAIN;
      R_AR:    rs_d = m_axi_arready ? R_R : R_AR;
      R_R: if (m_axi_rvalid) begin
        rs_d         = R_IDLE;
        dram_rdata_d = pick(m_axi_rdata, rlane_q, roff_q);
        dram_valid_d = 1'b1;
      end
      default: rs_d = R_IDLE;
    endcase
    if (rd_acc & lb_hit) begin
      dram_rdata_d = pick(lb_rd, lane, off);
      dram_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q        <= W_IDLE;
      rs_q         <= R_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      dram_rdata_q <= '0;
      dram_valid_q <= 1'b0;
      ra_q         <= '0;
      rlane_q      <= '0;
      roff_q       <= '0;
    end else begin
      wst_q        <= wst_d;
      rs_q         <= rs_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      wp_q         <= wp_q + QW'(push);
      rp_q         <= rp_q + QW'(pop);
      cnt_q        <= cnt_q + (QW+1)'(push) - (QW+1)'(pop);
      err_q        <= err_d;
      dram_rdata_q <= dram_rdata_d;
      dram_valid_q <= dram_valid_d;
      if (rd_acc) begin
        ra_q    <= base;
        rlane_q <= lane;
        roff_q  <= off;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wp_q] <= base;
      q_data[wp_q] <= wdata_e;
      q_strb[wp_q] <= wstrb_e;
    end
  end

`ifdef DRAM_LINEBUF_EN
  logic                    lb_v_q;
  logic [ADDR_W-LAB-1:0]   lb_tag_q;
  logic [AXI_DATA_W-1:0]   lb_data_q;
  logic                    lb_wt;
  assign lb_hit = lb_v_q & (lb_tag_q == dram_addr[ADDR_W-1:LAB]) & empty;
  assign lb_rd  = lb_data_q;
  assign lb_wt  = push & lb_v_q & (lb_tag_q == dram_addr[ADDR_W-1:LAB]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lb_v_q <= 1'b0;
    else if (err_d & ~err_q) lb_v_q <= 1'b0;
    else if (m_axi_rvalid & (rs_q == R_R)) lb_v_q <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (m_axi_rvalid & (rs_q == R_R)) begin
      lb_tag_q  <= ra_q[ADDR_W-1:LAB];
      lb_data_q <= m_axi_rdata;
    end else if (lb_wt) begin
      for (int i = 0; i < AB; i++)
        if (wstrb_e[i]) lb_data_q[8*i +: 8] <= wdata_e[8*i +: 8];
    end
  end
`else
  assign lb_hit = 1'b0;
  assign lb_rd  = '0;
`endif

  assign dram_rdata    = dram_rdata_q;
  assign dram_valid    = dram_valid_q;
  assign axi_err       = err_q;
  assign m_axi_araddr  = ra_q;
  assign m_axi_arvalid = rs_q == R_AR;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(LAB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_awaddr  = q_addr[rp_q];
  assign m_axi_awvalid = (wst_q == W_SEND) & ~aw_done_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(LAB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = q_data[rp_q];
  assign m_axi_wstrb   = q_strb[rp_q];
  assign m_axi_wvalid  = (wst_q == W_SEND) & ~w_done_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_rready  = 1'b1;
  assign m_axi_bready  = 1'b1;
endmodule
